// File: rtl/b4_equal_bist.sv
// Exhaustive built-in self-test for an external 4-bit equality comparator.
// Walks all 256 (A,B) pairs, counts wrong eq answers and records the first failing pair.
module b4_equal_bist #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] A,
  output logic [3:0] B,
  input  logic       eq,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [3:0] fail_a,
  output logic [3:0] fail_b
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Loaded on leaving DRIVE and counted down to zero, giving SETTLE_CYCLES WAIT cycles.
  localparam logic [3:0] WAIT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  idx_q;
  logic [3:0]  wait_q;
  logic [3:0]  a_q;
  logic [3:0]  b_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [8:0]  err_q;
  logic [3:0]  fail_a_q;
  logic [3:0]  fail_b_q;
  logic        mismatch;

  assign mismatch = eq ^ (a_q == b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 8'd0;
      wait_q   <= 4'd0;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 9'd0;
      fail_a_q <= 4'd0;
      fail_b_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            idx_q    <= 8'd0;
            err_q    <= 9'd0;
            fail_a_q <= 4'd0;
            fail_b_q <= 4'd0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= DRIVE;
          end
        end
        DRIVE: begin
          a_q     <= idx_q[7:4];
          b_q     <= idx_q[3:0];
          wait_q  <= WAIT_INIT;
          state_q <= WAIT;
        end
        WAIT: begin
          if (wait_q == 4'd0) state_q <= CHECK;
          else                wait_q  <= wait_q - 4'd1;
        end
        CHECK: begin
          if (mismatch) begin
            err_q <= err_q + 9'd1;
            // err_q is still zero only for the first mismatch of the run.
            if (err_q == 9'd0) begin
              fail_a_q <= a_q;
              fail_b_q <= b_q;
            end
          end
          if (idx_q == 8'd255) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == 9'd0) && !mismatch;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 8'd1;
            state_q <= DRIVE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;

endmodule

// File: tb/tb_b4_equal_bist.sv
// Self-checking bench: emulates good and faulty comparators around two BIST instances
// (SETTLE_CYCLES 1 and 3) and predicts run results with a plain loop over all 256 pairs.
module tb_b4_equal_bist;

  logic       clk;
  logic       rst_n;
  logic       start1, start3;
  logic [3:0] A1, B1, A3, B3;
  logic       eq1, eq3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [8:0] err1, err3;
  logic [3:0] fa1, fb1, fa3, fb3;

  int         mode;       // 0 good, 1 stuck-0, 2 stuck-1, 3 good xor flip mask
  logic [255:0] flip_vec;
  logic       d1_q, d2_q;

  int n_pass  = 0;
  int n_total = 0;

  b4_equal_bist #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(A1), .B(B1), .eq(eq1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_a(fa1), .fail_b(fb1)
  );

  b4_equal_bist #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .A(A3), .B(B3), .eq(eq3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_a(fa3), .fail_b(fb3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic comp(input logic [3:0] a, input logic [3:0] b,
                                input int m, input logic [255:0] fv);
    logic good;
    good = (a == b);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return good ^ fv[{a, b}];
      default: return good;
    endcase
  endfunction

  assign eq1 = comp(A1, B1, mode, flip_vec);

  // Correct comparator with two cycles of latency in front of the slow instance.
  always @(posedge clk) begin
    d1_q <= (A3 == B3);
    d2_q <= d1_q;
  end
  assign eq3 = d2_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Expected outcome of a full run, enumerating every pair in order.
  task automatic model(output int errs, output int fa, output int fb);
    errs = 0; fa = 0; fb = 0;
    for (int v = 0; v < 256; v++) begin
      int a, b;
      a = v / 16;
      b = v % 16;
      if (comp(4'(a), 4'(b), mode, flip_vec) != (a == b)) begin
        if (errs == 0) begin fa = a; fb = b; end
        errs++;
      end
    end
  endtask

  task automatic run1(input bit hold, output int cyc);
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1;
    if (!hold) start1 = 1'b0;
    check("busy_at_first_drive", busy1, 1);
    cyc = 0;
    while (!done1 && cyc < 4000) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic run_and_check(input string tag, input bit hold);
    int cyc, e, fa, fb;
    model(e, fa, fb);
    run1(hold, cyc);
    $display("run %s: cycles=%0d err=%0d fail=(%0d,%0d) pass=%0b", tag, cyc, err1, fa1, fb1, pass1);
    check({tag, "_cycles"}, cyc, 768);
    check({tag, "_done"}, done1, 1);
    check({tag, "_busy"}, busy1, 0);
    check({tag, "_err"}, err1, e);
    check({tag, "_fail_a"}, fa1, fa);
    check({tag, "_fail_b"}, fb1, fb);
    check({tag, "_pass"}, pass1, (e == 0));
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; mode = 0; flip_vec = '0;
    #2;
    check("rst_A", A1, 0);
    check("rst_B", B1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_pass", pass1, 0);
    check("rst_err", err1, 0);
    check("rst_fail_a", fa1, 0);
    check("rst_fail_b", fb1, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy1, 0);
    check("idle_done", done1, 0);

    mode = 0; run_and_check("good", 1'b0);
    mode = 1; run_and_check("stuck0", 1'b0);
    mode = 2; run_and_check("stuck1", 1'b0);
    for (int r = 0; r < 3; r++) begin
      mode = 3;
      for (int i = 0; i < 256; i++) flip_vec[i] = ($urandom_range(0, 15) == 0);
      run_and_check($sformatf("rand%0d", r), 1'b0);
    end

    // start held high through a run: one run, then immediate restart from DONE.
    mode = 0;
    run_and_check("hold", 1'b1);
    @(posedge clk); #1;
    check("hold_restart_busy", busy1, 1);
    check("hold_restart_done", done1, 0);
    start1 = 1'b0;

    // The restarted run began at the last edge; vector 100 is on A/B 302 cycles later.
    repeat (302) @(posedge clk);
    #1;
    check("mid_A", A1, 6);
    check("mid_B", B1, 4);
    check("mid_busy", busy1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_A", A1, 0);
    check("abort_B", B1, 0);
    check("abort_busy", busy1, 0);
    check("abort_done", done1, 0);
    check("abort_err", err1, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("after_abort_idle", busy1, 0);
    run_and_check("after_abort", 1'b0);

    // Slow comparator on the SETTLE_CYCLES=3 instance.
    @(negedge clk); start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    cyc = 0;
    while (!done3 && cyc < 6000) begin
      @(posedge clk); #1; cyc++;
    end
    $display("run slow: cycles=%0d err=%0d pass=%0b", cyc, err3, pass3);
    check("slow_cycles", cyc, 1280);
    check("slow_pass", pass3, 1);
    check("slow_err", err3, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/b4_equal_bist.md
B4_EQUAL_BIST -- requirements
Module: b4_equal_bist

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, setting the cycles waited between driving a vector and sampling eq; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a full self-test run.
REQ-005 The block SHALL have port A, output, 4 bits: operand A driven to the 4-bit equality comparator under test.
REQ-006 The block SHALL have port B, output, 4 bits: operand B driven to the comparator under test.
REQ-007 The block SHALL have port eq, input, 1 bit: equality result returned by the comparator under test.
REQ-008 The block SHALL have port busy, output, 1 bit: a run is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a run has completed and results are valid.
REQ-010 The block SHALL have port pass, output, 1 bit: high only when done=1 and err_count=0.
REQ-011 The block SHALL have port err_count, output, 9 bits: number of mismatching vectors in the current or last run.
REQ-012 The block SHALL have ports fail_a and fail_b, outputs, 4 bits each: A and B of the first mismatching vector.

Function
REQ-013 The block SHALL implement the states IDLE, DRIVE, WAIT, CHECK and DONE.
REQ-014 An 8-bit vector index idx SHALL drive A=idx[7:4] and B=idx[3:0]; a run covers idx 0..255 in ascending order, which is 256 vectors.
REQ-015 IDLE or DONE with start=1 SHALL clear idx, err_count, fail_a and fail_b, deassert done, and enter DRIVE on the next edge.
REQ-016 DRIVE SHALL register A and B from idx and hold them stable until the next DRIVE, then enter WAIT.
REQ-017 WAIT SHALL last exactly SETTLE_CYCLES cycles, then enter CHECK.
REQ-018 CHECK SHALL sample eq, compare it with expected = (A==B), and increment err_count on mismatch.
REQ-019 On the first mismatch of a run, CHECK SHALL latch A and B into fail_a and fail_b; later mismatches SHALL leave them unchanged.
REQ-020 CHECK with idx<255 SHALL increment idx and enter DRIVE.
REQ-021 CHECK with idx=255 SHALL enter DONE without wrapping idx.
REQ-022 Each vector SHALL take exactly SETTLE_CYCLES+2 cycles, so a run is 256*(SETTLE_CYCLES+2) cycles from first DRIVE to done.
REQ-023 busy SHALL be 1 in DRIVE, WAIT and CHECK, and 0 otherwise.
REQ-024 done SHALL be 1 only in DONE and SHALL hold until start or reset.
REQ-025 start SHALL be ignored while busy=1, including when held high through a whole run.
REQ-026 In DONE, start=1 SHALL immediately begin a new run.
REQ-027 err_count SHALL not overflow, since its maximum is 256 and it is 9 bits wide.
REQ-028 eq SHALL be sampled only in CHECK; eq glitches in other states SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL immediately force the state to IDLE and clear idx.
REQ-030 rst_n=0 SHALL immediately force A, B, busy, done, pass, err_count, fail_a and fail_b to 0.
REQ-031 Reset asserted mid-run SHALL abort the run with no partial result retained.
REQ-032 After rst_n rises, the block SHALL wait in IDLE for start.

Verification
REQ-033 Correct comparator, SETTLE_CYCLES=1 -> done=1 exactly 768 cycles after first DRIVE, pass=1, err_count=0.
REQ-034 eq stuck at 0 -> err_count=16, fail_a=0, fail_b=0, pass=0.
REQ-035 eq stuck at 1 -> err_count=240, fail_a=0, fail_b=1, pass=0.
REQ-036 start held high for the whole run -> a single run, done after 768 cycles; with start still high in DONE, a new run begins on the next edge.
REQ-037 rst_n pulsed low at idx=100 -> all outputs 0 immediately and state IDLE; a fresh start then completes with pass=1.
REQ-038 SETTLE_CYCLES=3 with the comparator delayed 2 cycles -> pass=1 after 1280 cycles.
